// File: rtl/rotary_entry_controller.sv
// Rotary hex word editor: rotation edges edit one nibble at a time, a short press
// selects the next lower nibble, a long press offers the word over valid/ready.
module rotary_entry_controller #(
    parameter int WIDTH       = 16,
    parameter int LONG_CYCLES = 25_000_000,
    localparam int NIBBLES    = WIDTH / 4,
    localparam int SELW       = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             right,
    input  logic             left,
    input  logic             down,
    input  logic             loadValue,
    input  logic [WIDTH-1:0] loadData,
    input  logic             commitReady,
    output logic [WIDTH-1:0] entryValue,
    output logic [SELW-1:0]  nibbleSel,
    output logic             commitValid,
    output logic             busy
);

    localparam int CW = $clog2(LONG_CYCLES + 1);
    localparam logic [SELW-1:0] SEL_MAX = SELW'(NIBBLES - 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(LONG_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        S_EDIT    = 2'd0,
        S_PRESS   = 2'd1,
        S_COMMIT  = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] entry_q;
    logic [SELW-1:0]  sel_q;
    logic             valid_q;
    logic             busy_q;
    logic [CW-1:0]    cnt_q;
    logic             right_q, left_q, down_q;

    logic             rise_r, rise_l, rise_d, fall_d;
    logic [WIDTH-1:0] entry_rot;
    logic [SELW-1:0]  sel_dec;

    always_comb begin
        rise_r = right & ~right_q;
        rise_l = left & ~left_q;
        rise_d = down & ~down_q;
        fall_d = ~down & down_q;
        sel_dec = (sel_q == '0) ? SEL_MAX : sel_q - SELW'(1);
        entry_rot = entry_q;
        for (int i = 0; i < NIBBLES; i++) begin
            if (sel_q == SELW'(i)) begin
                entry_rot[4*i +: 4] = rise_r ? entry_q[4*i +: 4] + 4'd1
                                             : entry_q[4*i +: 4] - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= S_EDIT;
            entry_q <= '0;
            sel_q   <= SEL_MAX;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            right_q <= 1'b1;
            left_q  <= 1'b1;
            down_q  <= 1'b1;
        end else begin
            right_q <= right;
            left_q  <= left;
            down_q  <= down;
            case (state_q)
                S_EDIT: begin
                    if (loadValue) begin
                        entry_q <= loadData;
                        sel_q   <= SEL_MAX;
                    end else if (rise_r ^ rise_l) begin
                        entry_q <= entry_rot;
                    end
                    // The sampling edge of the press already counts as one held cycle.
                    if (rise_d) begin
                        state_q <= S_PRESS;
                        busy_q  <= 1'b1;
                        cnt_q   <= CW'(1);
                    end
                end
                S_PRESS: begin
                    if (fall_d) begin
                        state_q <= S_EDIT;
                        busy_q  <= 1'b0;
                        sel_q   <= sel_dec;
                    end else if (down) begin
                        if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CW'(1);
                        if (cnt_q >= CNT_LAST) begin
                            state_q <= S_COMMIT;
                            valid_q <= 1'b1;
                        end
                    end
                end
                S_COMMIT: begin
                    if (commitReady) begin
                        state_q <= S_RELEASE;
                        valid_q <= 1'b0;
                    end
                end
                S_RELEASE: begin
                    if (!down) begin
                        state_q <= S_EDIT;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_EDIT;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign entryValue  = entry_q;
    assign nibbleSel   = sel_q;
    assign commitValid = valid_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_rotary_entry_controller.sv
// Bench for rotary_entry_controller: directed scenarios with literal expectations,
// then random rotation/press/handshake traffic compared every cycle against a word-level model.
module tb_rotary_entry_controller;

    localparam int WIDTH   = 16;
    localparam int LONG    = 8;
    localparam int NIBBLES = WIDTH / 4;
    localparam int SELW    = 2;

    logic             clk = 1'b0;
    logic             resetN = 1'b0;
    logic             right = 1'b0, left = 1'b0, down = 1'b0;
    logic             loadValue = 1'b0;
    logic [WIDTH-1:0] loadData = '0;
    logic             commitReady = 1'b0;
    logic [WIDTH-1:0] entryValue;
    logic [SELW-1:0]  nibbleSel;
    logic             commitValid;
    logic             busy;

    rotary_entry_controller #(.WIDTH(WIDTH), .LONG_CYCLES(LONG)) dut (
        .clk(clk), .resetN(resetN), .right(right), .left(left), .down(down),
        .loadValue(loadValue), .loadData(loadData), .commitReady(commitReady),
        .entryValue(entryValue), .nibbleSel(nibbleSel),
        .commitValid(commitValid), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mode 0=editing, 1=button held, 2=word offered, 3=waiting for release
    int               m_mode = 0;
    int               m_held = 0;
    int               m_sel = NIBBLES - 1;
    bit               m_valid = 0;
    logic [WIDTH-1:0] m_val = '0;
    bit               p_r = 1, p_l = 1, p_d = 1;

    function automatic logic [WIDTH-1:0] step_nibble(input logic [WIDTH-1:0] v,
                                                     input int sel, input int delta);
        int nib;
        logic [WIDTH-1:0] mask;
        nib  = int'((v >> (4 * sel)) & WIDTH'(15));
        nib  = (nib + delta + 16) % 16;
        mask = WIDTH'(15) << (4 * sel);
        return (v & ~mask) | (WIDTH'(nib) << (4 * sel));
    endfunction

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            m_mode = 0; m_held = 0; m_sel = NIBBLES - 1; m_valid = 0; m_val = '0;
            p_r = 1; p_l = 1; p_d = 1;
        end else begin
            bit er, el, ed;
            er = right && !p_r;
            el = left && !p_l;
            ed = down && !p_d;
            case (m_mode)
                0: begin
                    if (loadValue) begin
                        m_val = loadData;
                        m_sel = NIBBLES - 1;
                    end else if (er && !el) m_val = step_nibble(m_val, m_sel, 1);
                    else if (el && !er) m_val = step_nibble(m_val, m_sel, -1);
                    if (ed) begin m_mode = 1; m_held = 1; end
                end
                1: begin
                    if (!down) begin
                        m_mode = 0;
                        m_sel = (m_sel + NIBBLES - 1) % NIBBLES;
                    end else begin
                        m_held++;
                        if (m_held >= LONG) begin m_mode = 2; m_valid = 1; end
                    end
                end
                2: if (commitReady) begin m_mode = 3; m_valid = 0; end
                default: if (!down) m_mode = 0;
            endcase
            p_r = right; p_l = left; p_d = down;
        end
    end

    always @(negedge clk) begin
        chk("entryValue", int'(entryValue), int'(m_val));
        chk("nibbleSel", int'(nibbleSel), m_sel);
        chk("commitValid", int'(commitValid), int'(m_valid));
        chk("busy", int'(busy), int'(m_mode != 0));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_right();
        right = 1; tick(); right = 0; tick();
    endtask

    task automatic pulse_left();
        left = 1; tick(); left = 0; tick();
    endtask

    task automatic short_press();
        down = 1; tick(); down = 0; tick();
    endtask

    initial begin
        int found;
        right = 1;
        repeat (3) tick();
        resetN = 1;
        repeat (5) tick();
        chk("reset_value", int'(entryValue), 0);
        chk("reset_sel", int'(nibbleSel), 3);
        chk("reset_valid", int'(commitValid), 0);
        right = 0;
        tick();

        loadData = 16'h12F0; loadValue = 1; tick(); loadValue = 0; tick();
        pulse_right();
        chk("load_then_right", int'(entryValue), 'h22F0);
        short_press();
        chk("short_press_sel", int'(nibbleSel), 2);
        pulse_right(); pulse_right();
        chk("nibble2_steps", int'(entryValue), 'h24F0);
        short_press(); short_press();
        chk("sel_down_to_0", int'(nibbleSel), 0);
        pulse_left();
        chk("left_wrap", int'(entryValue), 'h24FF);
        short_press();
        chk("sel_wrap", int'(nibbleSel), 3);

        down = 1;
        found = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (commitValid) begin found = i; break; end
        end
        chk("long_press_latency", found, LONG);
        for (int i = 0; i < 10; i++) begin
            right = i[0];
            tick();
            chk("held_value", int'(entryValue), 'h24FF);
            chk("held_valid", int'(commitValid), 1);
        end
        right = 0;
        commitReady = 1; tick(); commitReady = 0;
        chk("handshake_drop", int'(commitValid), 0);
        chk("release_busy", int'(busy), 1);
        down = 0; tick();
        chk("release_idle", int'(busy), 0);
        chk("release_sel", int'(nibbleSel), 3);

        right = 1; left = 1; tick(); right = 0; left = 0; tick();
        chk("simul_edges", int'(entryValue), 'h24FF);
        loadData = 16'hA5C3; loadValue = 1; right = 1; tick();
        loadValue = 0; right = 0; tick();
        chk("load_beats_edge", int'(entryValue), 'hA5C3);

        down = 1;
        repeat (LONG) tick();
        chk("commit_reached", int'(commitValid), 1);
        #2 resetN = 0;
        #1;
        chk("async_valid", int'(commitValid), 0);
        chk("async_value", int'(entryValue), 0);
        down = 0;
        tick(); tick();
        resetN = 1;
        tick();

        for (int c = 0; c < 4000; c++) begin
            right = ($urandom_range(0, 2) == 0);
            left  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) == 0) down = ~down;
            loadValue = ($urandom_range(0, 15) == 0);
            loadData = WIDTH'($urandom);
            commitReady = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
